// File: rtl/uart_rx_core.sv
// UART receive front end: 2-flop synchroniser, start detect, mid-bit sampling, 8N1 framing.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_rx_core (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        rx_en_i,
   input  logic [15:0] baud_i,
   input  logic        rx_i,
   output logic [7:0]  rx_byte_o,
   output logic        rx_done_o,
   output logic        start_det_o,
   output logic        frame_err_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY  = 3'd3,
`endif
      S_STOP    = 3'd4,
      S_CLEANUP = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_stateNext;
   logic        r_sync1;
   logic        r_sync2;
   logic [15:0] r_baudQ;
   logic [15:0] r_cnt;
   logic [2:0]  r_idx;
   logic [7:0]  r_shift;
   logic [7:0]  r_rxByte;
   logic        r_done;
   logic        r_startDet;
   logic        r_frameErr;

   logic [15:0] w_baudQNext;
   logic [15:0] w_cntNext;
   logic [2:0]  w_idxNext;
   logic [7:0]  w_shiftNext;
   logic [7:0]  w_rxByteNext;
   logic        w_done;
   logic        w_startDet;
   logic        w_frameErr;
   logic        w_rxS;
   logic        w_startCond;
   logic        w_halfHit;
   logic        w_bitHit;
   logic        w_stopGood;

   assign w_rxS       = r_sync2;
   assign w_startCond = !w_rxS && (baud_i >= 16'd4);
   assign w_halfHit   = (r_cnt == ((r_baudQ >> 1) - 16'd1));
   assign w_bitHit    = (r_cnt == (r_baudQ - 16'd1));

`ifdef UART_RX_PARITY_EN
   logic r_parity;
   logic w_parityNext;
   assign w_stopGood = w_rxS && ((^r_shift) == r_parity);
`else
   assign w_stopGood = w_rxS;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         r_baudQ    <= 16'd0;
         r_cnt      <= 16'd0;
         r_idx      <= 3'd0;
         r_shift    <= 8'h00;
         r_rxByte   <= 8'h00;
         r_done     <= 1'b0;
         r_startDet <= 1'b0;
         r_frameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         r_state    <= w_stateNext;
         r_sync1    <= rx_i;
         r_sync2    <= r_sync1;
         r_baudQ    <= w_baudQNext;
         r_cnt      <= w_cntNext;
         r_idx      <= w_idxNext;
         r_shift    <= w_shiftNext;
         r_rxByte   <= w_rxByteNext;
         r_done     <= w_done;
         r_startDet <= w_startDet;
         r_frameErr <= w_frameErr;
`ifdef UART_RX_PARITY_EN
         r_parity   <= w_parityNext;
`endif
      end
   end

   always_comb begin
      w_stateNext = r_state;
      if (!rx_en_i) begin
         w_stateNext = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:    if (w_startCond) w_stateNext = S_START;
            S_START:   if (w_halfHit) w_stateNext = w_rxS ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
            S_DATA:    if (w_bitHit && (r_idx == 3'd7)) w_stateNext = S_PARITY;
            S_PARITY:  if (w_bitHit) w_stateNext = S_STOP;
`else
            S_DATA:    if (w_bitHit && (r_idx == 3'd7)) w_stateNext = S_STOP;
`endif
            S_STOP:    if (w_bitHit) w_stateNext = S_CLEANUP;
            S_CLEANUP: w_stateNext = S_IDLE;
            default:   w_stateNext = S_IDLE;
         endcase
      end
   end

   // Strobes are computed here and registered, so every output is a flop.
   always_comb begin
      w_baudQNext  = r_baudQ;
      w_cntNext    = r_cnt;
      w_idxNext    = r_idx;
      w_shiftNext  = r_shift;
      w_rxByteNext = r_rxByte;
      w_done       = 1'b0;
      w_startDet   = 1'b0;
      w_frameErr   = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_parityNext = r_parity;
`endif
      if (!rx_en_i) begin
         w_cntNext = 16'd0;
         w_idxNext = 3'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_startCond) begin
                  w_baudQNext = baud_i;
                  w_cntNext   = 16'd0;
                  w_startDet  = 1'b1;
               end
            end
            S_START: begin
               if (w_halfHit) begin
                  w_cntNext = 16'd0;
                  w_idxNext = 3'd0;
               end else begin
                  w_cntNext = r_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (w_bitHit) begin
                  w_shiftNext = {w_rxS, r_shift[7:1]};
                  w_cntNext   = 16'd0;
                  w_idxNext   = r_idx + 3'd1;
               end else begin
                  w_cntNext = r_cnt + 16'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (w_bitHit) begin
                  w_parityNext = w_rxS;
                  w_cntNext    = 16'd0;
               end else begin
                  w_cntNext = r_cnt + 16'd1;
               end
            end
`endif
            S_STOP: begin
               if (w_bitHit) begin
                  w_cntNext = 16'd0;
                  if (w_stopGood) begin
                     w_rxByteNext = r_shift;
                     w_done       = 1'b1;
                  end else begin
                     w_frameErr = 1'b1;
                  end
               end else begin
                  w_cntNext = r_cnt + 16'd1;
               end
            end
            S_CLEANUP: begin
               w_cntNext = 16'd0;
               w_idxNext = 3'd0;
            end
            default: begin
               w_cntNext = 16'd0;
               w_idxNext = 3'd0;
            end
         endcase
      end
   end

   assign rx_byte_o   = r_rxByte;
   assign rx_done_o   = r_done;
   assign start_det_o = r_startDet;
   assign frame_err_o = r_frameErr;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed testbench for uart_rx_core in the default 8N1 build.
// Strobes are tallied on the falling clock edge and compared against hand-computed counts, bytes and latencies.
module tb_uart_rx_core;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        rx_en_i;
   logic [15:0] baud_i;
   logic        rx_i;
   logic [7:0]  rx_byte_o;
   logic        rx_done_o;
   logic        start_det_o;
   logic        frame_err_o;

   int cycleCount = 0;
   int startCount = 0;
   int doneCount  = 0;
   int ferrCount  = 0;
   int bothCount  = 0;
   int startCycle = 0;
   int doneCycle  = 0;
   int dropCycle  = 0;
   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;
   int baseStart;
   int baseDone;
   int baseFerr;
   logic [7:0] lastByte = 8'h00;

   uart_rx_core dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .rx_en_i     (rx_en_i),
      .baud_i      (baud_i),
      .rx_i        (rx_i),
      .rx_byte_o   (rx_byte_o),
      .rx_done_o   (rx_done_o),
      .start_det_o (start_det_o),
      .frame_err_o (frame_err_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cycleCount++;

   // Count strobe-high cycles, so a pulse stretched past one cycle shows up as an extra count.
   always @(negedge clk_i) begin
      if (start_det_o) begin
         startCount++;
         startCycle = cycleCount;
      end
      if (rx_done_o) begin
         doneCount++;
         doneCycle = cycleCount;
         lastByte  = rx_byte_o;
      end
      if (frame_err_o) ferrCount++;
      if (rx_done_o && frame_err_o) bothCount++;
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)",
                tag, observed, observed, expected, expected);
      end
   endtask

   // Drives one frame LSB first, each bit held bitCycles clocks, changing on falling edges.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int bitCycles);
      @(negedge clk_i);
      rx_i      = 1'b0;
      dropCycle = cycleCount;
      repeat (bitCycles) @(negedge clk_i);
      for (int i = 0; i < 8; i++) begin
         rx_i = data[i];
         repeat (bitCycles) @(negedge clk_i);
      end
      rx_i = stopBit;
      repeat (bitCycles) @(negedge clk_i);
      rx_i = 1'b1;
   endtask

   task automatic takeBase();
      baseStart = startCount;
      baseDone  = doneCount;
      baseFerr  = ferrCount;
   endtask

   initial begin
      rst_ni  = 1'b0;
      rx_en_i = 1'b1;
      baud_i  = 16'd16;
      rx_i    = 1'b1;
      repeat (3) @(negedge clk_i);
      checkOutput("reset_byte", int'(rx_byte_o), 8'h00);
      checkOutput("reset_done", int'(rx_done_o), 0);
      checkOutput("reset_start", int'(start_det_o), 0);
      checkOutput("reset_ferr", int'(frame_err_o), 0);
      rst_ni = 1'b1;
      repeat (5) @(negedge clk_i);

      $display("[TB] clean frame 0xA5 at 16 clocks per bit");
      takeBase();
      applyStimulus(8'hA5, 1'b1, 16);
      repeat (20) @(negedge clk_i);
      checkOutput("clean_start_count", startCount - baseStart, 1);
      checkOutput("clean_done_count", doneCount - baseDone, 1);
      checkOutput("clean_ferr_count", ferrCount - baseFerr, 0);
      checkOutput("clean_byte", int'(rx_byte_o), 8'hA5);
      checkOutput("clean_start_latency", startCycle - dropCycle, 3);
      checkOutput("clean_done_latency", doneCycle - startCycle, 152);

      $display("[TB] reset asserted in the middle of a frame");
      @(negedge clk_i);
      rx_i = 1'b0;
      repeat (56) @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      checkOutput("midreset_byte", int'(rx_byte_o), 8'h00);
      checkOutput("midreset_done", int'(rx_done_o), 0);
      checkOutput("midreset_start", int'(start_det_o), 0);
      checkOutput("midreset_ferr", int'(frame_err_o), 0);
      rx_i = 1'b1;
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (5) @(negedge clk_i);
      takeBase();
      applyStimulus(8'hA5, 1'b1, 16);
      repeat (20) @(negedge clk_i);
      checkOutput("after_reset_done_count", doneCount - baseDone, 1);
      checkOutput("after_reset_byte", int'(rx_byte_o), 8'hA5);
      checkOutput("after_reset_ferr_count", ferrCount - baseFerr, 0);
      checkOutput("after_reset_done_latency", doneCycle - startCycle, 152);

      $display("[TB] three-cycle glitch on the line");
      takeBase();
      @(negedge clk_i);
      rx_i = 1'b0;
      repeat (3) @(negedge clk_i);
      rx_i = 1'b1;
      repeat (40) @(negedge clk_i);
      checkOutput("glitch_start_count", startCount - baseStart, 1);
      checkOutput("glitch_done_count", doneCount - baseDone, 0);
      checkOutput("glitch_ferr_count", ferrCount - baseFerr, 0);

      $display("[TB] frame 0x3C with a low stop bit");
      takeBase();
      applyStimulus(8'h3C, 1'b0, 16);
      repeat (40) @(negedge clk_i);
      checkOutput("badstop_ferr_count", ferrCount - baseFerr, 1);
      checkOutput("badstop_done_count", doneCount - baseDone, 0);
      checkOutput("badstop_byte_kept", int'(rx_byte_o), 8'hA5);

      $display("[TB] enable dropped during data bit 3");
      takeBase();
      fork
         applyStimulus(8'h5A, 1'b1, 16);
         begin
            repeat (72) @(negedge clk_i);
            rx_en_i = 1'b0;
         end
      join
      repeat (5) @(negedge clk_i);
      rx_en_i = 1'b1;
      repeat (20) @(negedge clk_i);
      checkOutput("abort_start_count", startCount - baseStart, 1);
      checkOutput("abort_done_count", doneCount - baseDone, 0);
      checkOutput("abort_ferr_count", ferrCount - baseFerr, 0);
      checkOutput("abort_byte_kept", int'(rx_byte_o), 8'hA5);
      takeBase();
      applyStimulus(8'h5A, 1'b1, 16);
      repeat (20) @(negedge clk_i);
      checkOutput("reenable_done_count", doneCount - baseDone, 1);
      checkOutput("reenable_byte", int'(rx_byte_o), 8'h5A);

      $display("[TB] back-to-back 0x00 and 0xFF with baud_i changed mid-frame");
      takeBase();
      applyStimulus(8'h00, 1'b1, 16);
      checkOutput("b2b_first_byte", int'(lastByte), 8'h00);
      repeat (15) @(negedge clk_i);
      fork
         applyStimulus(8'hFF, 1'b1, 16);
         begin
            repeat (60) @(negedge clk_i);
            baud_i = 16'd7;
         end
      join
      baud_i = 16'd16;
      repeat (20) @(negedge clk_i);
      checkOutput("b2b_done_count", doneCount - baseDone, 2);
      checkOutput("b2b_second_byte", int'(lastByte), 8'hFF);
      checkOutput("b2b_ferr_count", ferrCount - baseFerr, 0);

      $display("[TB] smallest accepted baud_i of 4");
      baud_i = 16'd4;
      takeBase();
      applyStimulus(8'h96, 1'b1, 4);
      repeat (20) @(negedge clk_i);
      checkOutput("baud4_done_count", doneCount - baseDone, 1);
      checkOutput("baud4_byte", int'(rx_byte_o), 8'h96);
      checkOutput("baud4_done_latency", doneCycle - startCycle, 38);

      $display("[TB] baud_i of 3 ignores frames");
      baud_i = 16'd3;
      takeBase();
      applyStimulus(8'h69, 1'b1, 3);
      repeat (20) @(negedge clk_i);
      checkOutput("baud3_start_count", startCount - baseStart, 0);
      checkOutput("baud3_done_count", doneCount - baseDone, 0);
      checkOutput("baud3_byte_kept", int'(rx_byte_o), 8'h96);
      baud_i = 16'd16;

      checkOutput("strobes_exclusive", bothCount, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
